// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling, glitch rejection and framing-error detection
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRx,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrame_err,
  output logic       oBusy
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DW  = ($clog2(DIV) > 16) ? $clog2(DIV) : 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic r_rx_s1, r_rx_s2, r_rx_prev;
  logic [DW-1:0] r_div;
  logic [3:0] r_tick;
  logic [2:0] r_idx;
  logic [7:0] r_shift;
  logic w_tick, w_fall, w_mid, w_last;
  assign w_tick = (r_div == DW'(DIV - 1));
  assign w_fall = r_rx_prev & ~r_rx_s2;
  assign w_mid  = w_tick && (r_tick == 4'd7);
  assign w_last = w_tick && (r_tick == 4'd15);
  assign oBusy  = (r_state != IDLE);
  // two-flop synchronizer plus previous sample for falling-edge detection
  always_ff @(posedge iClk) begin
    r_rx_s1   <= iRst ? 1'b1 : iRx;
    r_rx_s2   <= iRst ? 1'b1 : r_rx_s1;
    r_rx_prev <= iRst ? 1'b1 : r_rx_s2;
  end
  // next-state logic; a mid-start sample of 1 is a glitch and aborts the frame
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_fall ? START : IDLE;
      START:   w_next = w_mid ? (r_rx_s2 ? IDLE : DATA) : START;
      DATA:    w_next = (w_last && r_idx == 3'd7) ? STOP : DATA;
      STOP:    w_next = w_last ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  // state register, oversample divider (held at 0 in IDLE so ticks align to the start edge), tick counter, bit index
  always_ff @(posedge iClk) begin
    r_state <= iRst ? IDLE : w_next;
    r_div   <= (iRst || r_state == IDLE || w_tick) ? '0 : r_div + DW'(1);
    r_tick  <= (iRst || r_state == IDLE || (r_state == START && w_mid)) ? 4'd0 : r_tick + 4'(w_tick);
    r_idx   <= (iRst || r_state != DATA) ? 3'd0 : r_idx + 3'(w_last);
  end
  // data shift register, LSB first
  always_ff @(posedge iClk) begin
    if (iRst) r_shift <= 8'h00;
    else if (r_state == DATA && w_last) r_shift[r_idx] <= r_rx_s2;
  end
  // registered result pulses at the stop-bit sample; oData only changes on a good frame
  always_ff @(posedge iClk) begin
    oValid     <= !iRst && r_state == STOP && w_last && r_rx_s2;
    oFrame_err <= !iRst && r_state == STOP && w_last && !r_rx_s2;
    if (iRst) oData <= 8'h00;
    else if (r_state == STOP && w_last && r_rx_s2) oData <= r_shift;
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus against a byte-level scoreboard of expected receptions
module tb_uart_rx;
  localparam int DIV = 10;
  localparam int BIT = 16 * DIV;
  logic clk, rst, rx;
  logic [7:0] o_data;
  logic o_valid, o_frame_err, o_busy;
  int n_checks = 0, n_fail = 0;
  logic [7:0] got_q[$], exp_q[$];
  int got_ferr = 0, exp_ferr = 0;
  logic [7:0] exp_data = 8'h00;
  logic prev_pulse = 1'b0;
  uart_rx #(.CLK_FREQ(1650), .BAUD_RATE(10)) dut (
    .iClk(clk), .iRst(rst), .iRx(rx), .oData(o_data),
    .oValid(o_valid), .oFrame_err(o_frame_err), .oBusy(o_busy)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid | o_frame_err) begin
        check("pulse_excl", 32'(o_valid & o_frame_err), 32'd0);
        check("pulse_width", 32'(prev_pulse), 32'd0);
      end
      if (o_valid) got_q.push_back(o_data);
      if (o_frame_err) got_ferr++;
    end
    prev_pulse = o_valid | o_frame_err;
  end
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int bp);
    drive(1'b0, bp);
    for (int i = 0; i < 8; i++) drive(b[i], bp);
    drive(stop, bp);
    if (stop) begin
      exp_q.push_back(b);
      exp_data = b;
    end else exp_ferr++;
  endtask
  task automatic settle(input string tag);
    int n = 0;
    while (o_busy && n < 4 * BIT) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
    repeat (4) @(negedge clk);
    check({tag, "_nvalid"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) check({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    got_q.delete();
    exp_q.delete();
    check({tag, "_nferr"}, got_ferr, exp_ferr);
    got_ferr = 0;
    exp_ferr = 0;
    check({tag, "_odata"}, 32'(o_data), 32'(exp_data));
  endtask
  initial begin
    logic [7:0] b;
    logic [7:0] f3;
    logic s;
    int bp;
    rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    drive(1'b1, 20);
    send(8'hA5, 1'b1, BIT);
    check("a5_busy_end", 32'(o_busy), 32'd0);
    settle("a5");
    send(8'h00, 1'b1, BIT);
    send(8'hFF, 1'b1, BIT);
    settle("b2b");
    drive(1'b0, 30);
    drive(1'b1, 45);
    check("glitch_busy_hi", 32'(o_busy), 32'd1);
    drive(1'b1, 20);
    check("glitch_busy_lo", 32'(o_busy), 32'd0);
    settle("glitch");
    send(8'h3C, 1'b0, BIT);
    drive(1'b0, 3 * BIT);
    check("ferr_hold_busy", 32'(o_busy), 32'd0);
    drive(1'b1, BIT);
    settle("ferr");
    f3 = 8'hF3;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(f3[i], BIT);
    drive(1'b1, BIT / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_data", 32'(o_data), 32'h00);
    exp_data = 8'h00;
    drive(1'b1, BIT / 2 - 1 + 4 * BIT);
    settle("midrst");
    send(8'h5A, 1'b1, BIT);
    settle("after_rst");
    send(8'h81, 1'b1, BIT + 3);
    settle("skew_p");
    send(8'h81, 1'b1, BIT - 3);
    settle("skew_m");
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      s = ($urandom_range(3) != 0);
      bp = BIT + int'($urandom_range(6)) - 3;
      send(b, s, bp);
      drive(1'b1, s ? int'($urandom_range(20)) : BIT);
      if (i % 4 == 3) settle("rnd");
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate in bit/s.
REQ-003 iClk  input  1  sole clock; all state updates on the rising edge.
REQ-004 iRst  input  1  reset; synchronous, active-high.
REQ-005 iRx  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-006 oData  output  8  last correctly framed byte.
REQ-007 oValid  output  1  one-cycle pulse when oData is updated.
REQ-008 oFrame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 oBusy  output  1  high while the FSM is in any state other than IDLE.

Function
REQ-010 iRx SHALL pass through a 2-flop synchronizer before any use; all timing below refers to the synchronized signal rxs.
REQ-011 An internal oversample divider SHALL count 0..DIV-1 and emit a one-cycle tick on reaching DIV-1, where DIV = CLK_FREQ/(BAUD_RATE*16) with integer truncation (325 at defaults).
REQ-012 The divider counter SHALL be at least 16 bits wide.
REQ-013 The divider SHALL restart at 0 in the cycle the FSM leaves IDLE, so ticks are phase-aligned to the start edge.
REQ-014 A 4-bit tick counter and a 3-bit bit index SHALL sequence the frame; the tick counter wraps 15->0.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: on a rxs falling edge (previous sample 1, current 0), go to START and clear the tick counter; otherwise remain in IDLE.
REQ-017 START: on the 8th tick (mid start bit), if rxs=0 go to DATA with the tick counter and bit index cleared; if rxs=1 treat the edge as a glitch and return to IDLE with no output pulse.
REQ-018 DATA: on every 16th tick, sample rxs into shift register bit [bit index], LSB first.
REQ-019 DATA: after the sample at bit index 7, go to STOP.
REQ-020 STOP: on the 16th tick, sample rxs.
REQ-021 STOP, sample 1: load oData from the shift register, pulse oValid, and return to IDLE.
REQ-022 STOP, sample 0: pulse oFrame_err, leave oData unchanged, and return to IDLE.
REQ-023 oValid and oFrame_err SHALL be registered, assert in the iClk cycle after the stop-sample tick, last exactly one cycle, and never assert together.
REQ-024 After a framing error, a new frame SHALL start only on a fresh high-to-low edge; a line held low SHALL NOT retrigger START.
REQ-025 A start edge arriving in the cycle the FSM returns to IDLE SHALL be detected, so back-to-back frames with no idle gap are received.
REQ-026 oBusy SHALL be combinational from the state: 1 in START, DATA, STOP; 0 in IDLE.

Reset
REQ-027 iRst=1 at a rising edge SHALL force state IDLE and clear the divider, tick counter, bit index, and shift register.
REQ-028 The same reset SHALL set oData=0x00, oValid=0, oFrame_err=0, and both synchronizer flops plus the edge-detect register to 1.
REQ-029 Reset SHALL take priority over every other event, including a reset in the middle of a frame.
REQ-030 The first frame after reset deasserts SHALL require a fresh falling edge.

Verification (defaults; bit period = 16*325 = 5200 clocks)
REQ-031 Send 0xA5 (8N1, 5200 clocks/bit) -> one oValid pulse, oData=0xA5, oFrame_err never high, oBusy low within 8*325+3 clocks of the stop-bit midpoint.
REQ-032 Send 0x00 then 0xFF back-to-back with no idle gap -> two oValid pulses, oData=0x00 then 0xFF.
REQ-033 Drive a low glitch of 1000 clocks on an idle line -> no oValid, no oFrame_err; oBusy high for about 2600 clocks, then 0.
REQ-034 Send 0x3C with the stop bit low, then idle high -> one oFrame_err pulse, no oValid, oData keeps its prior value.
REQ-035 Assert iRst for 1 cycle mid data bit 4 of a frame -> next cycle state IDLE, oBusy=0, oData=0x00; the rest of the frame produces no pulse; the next full frame 0x5A is received correctly.
REQ-036 Send 0x81 at +2% and -2% bit-period skew (5304 and 5096 clocks/bit) -> oData=0x81 with oValid in both cases.
